// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
// Opcodes are the base RV32I majors also used by the main decoder.
package pipeline_ctrl_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } state_t;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_B   = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

endpackage

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX feeding a source of the ID instruction.
// x0 is hardwired zero, so it never creates a dependency.
module hazard_detect
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  output logic                  load_use
);

  logic rd_nz;
  logic hit1;
  logic hit2;

  assign rd_nz    = (ex_rd != '0);
  assign hit1     = id_use_rs1 && (id_rs1 == ex_rd);
  assign hit2     = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_mem_read && rd_nz && (hit1 || hit2);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller: stage enables, flushes, memory wait,
// halt on illegal opcode or memory timeout, and a stall counter.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_illegal,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mem_read,
  input  logic                  ex_branch_taken,
  input  logic                  mem_mem_read,
  input  logic                  mem_mem_write,
  input  logic                  dmem_ready,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_en,
  output logic                  memwb_bubble,
  output logic                  dmem_req,
  output logic                  halted,
  output logic                  timeout_err,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int WC_W = $clog2(MEM_TIMEOUT);
  localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT - 1);

  state_t          state;
  state_t          state_n;
  logic [WC_W-1:0] wait_cnt;
  logic [WC_W-1:0] wait_n;
  logic            to_n;
  logic            load_use;
  logic            mem_access;
  logic            mem_stall;
  logic            go_halt;

  hazard_detect #(
    .REG_ADDR_W (REG_ADDR_W)
  ) u_hazard (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign mem_access = mem_mem_read || mem_mem_write;
  assign mem_stall  = mem_access && !dmem_ready;
  // illegal only counts when nothing of higher priority squashes or holds ID
  assign go_halt    = id_illegal && !ex_branch_taken && !load_use;
  assign halted     = (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      timeout_err <= 1'b0;
      stall_count <= '0;
    end else begin
      state       <= state_n;
      wait_cnt    <= wait_n;
      timeout_err <= to_n;
      if (!pc_en && state != HALT && stall_count != '1)
        stall_count <= stall_count + 1'b1;
    end
  end

  always_comb begin
    state_n = state;
    wait_n  = wait_cnt;
    to_n    = timeout_err;
    unique case (state)
      RUN: begin
        if (mem_stall) begin
          state_n = MEM_WAIT;
          wait_n  = WC_W'(1);
        end else if (go_halt) begin
          state_n = HALT;
        end
      end
      MEM_WAIT: begin
        if (mem_stall) begin
          if (wait_cnt == WC_MAX) begin
            state_n = HALT;
            to_n    = 1'b1;
          end else begin
            wait_n = wait_cnt + 1'b1;
          end
        end else begin
          state_n = go_halt ? HALT : RUN;
          wait_n  = '0;
        end
      end
      HALT: state_n = HALT;
      default: begin
        state_n = RUN;
        wait_n  = '0;
      end
    endcase
  end

  always_comb begin
    pc_en        = 1'b1;
    ifid_en      = 1'b1;
    ifid_flush   = 1'b0;
    idex_flush   = 1'b0;
    exmem_en     = 1'b1;
    memwb_bubble = 1'b0;
    dmem_req     = mem_access;
    if (rst) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      exmem_en     = 1'b0;
      ifid_flush   = 1'b1;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
      dmem_req     = 1'b0;
    end else if (state == HALT) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      exmem_en     = 1'b0;
      idex_flush   = 1'b1;
      memwb_bubble = 1'b1;
      dmem_req     = 1'b0;
    end else if (mem_stall) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with MEM_TIMEOUT=4.
// Inputs change on the falling edge; outputs are checked 1ns later.
module tb_pipeline_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_use_rs1, id_use_rs2, id_illegal;
  logic        ex_mem_read, ex_branch_taken;
  logic        mem_mem_read, mem_mem_write, dmem_ready;
  logic        pc_en, ifid_en, ifid_flush, idex_flush;
  logic        exmem_en, memwb_bubble, dmem_req;
  logic        halted, timeout_err;
  logic [31:0] stall_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pipeline_ctrl #(
    .REG_ADDR_W  (5),
    .MEM_TIMEOUT (4),
    .CNT_W       (32)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_use_rs1      (id_use_rs1),
    .id_use_rs2      (id_use_rs2),
    .id_illegal      (id_illegal),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .mem_mem_read    (mem_mem_read),
    .mem_mem_write   (mem_mem_write),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .ifid_en         (ifid_en),
    .ifid_flush      (ifid_flush),
    .idex_flush      (idex_flush),
    .exmem_en        (exmem_en),
    .memwb_bubble    (memwb_bubble),
    .dmem_req        (dmem_req),
    .halted          (halted),
    .timeout_err     (timeout_err),
    .stall_count     (stall_count)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // packed view: pc_en ifid_en ifid_flush idex_flush exmem_en bubble req
  function automatic logic [6:0] ctl();
    return {pc_en, ifid_en, ifid_flush, idex_flush,
            exmem_en, memwb_bubble, dmem_req};
  endfunction

  task automatic idle();
    id_rs1 = 0; id_rs2 = 0; ex_rd = 0;
    id_use_rs1 = 0; id_use_rs2 = 0; id_illegal = 0;
    ex_mem_read = 0; ex_branch_taken = 0;
    mem_mem_read = 0; mem_mem_write = 0; dmem_ready = 0;
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    step();
    chk("rst_ctl", 32'(ctl()), 32'b0011010);
    step();
    chk("rst_cnt", stall_count, 0);
    chk("rst_halt", 32'(halted), 0);
    chk("rst_to", 32'(timeout_err), 0);

    // load-use on rs1
    @(negedge clk);
    rst = 1'b0;
    ex_mem_read = 1; ex_rd = 5; id_rs1 = 5; id_use_rs1 = 1;
    #1;
    chk("lu_ctl", 32'(ctl()), 32'b0001100);
    chk("lu_cnt0", stall_count, 0);
    @(negedge clk);
    idle();
    #1;
    chk("lu_after", 32'(ctl()), 32'b1100100);
    chk("lu_cnt1", stall_count, 1);

    // same pattern on x0: no hazard
    @(negedge clk);
    ex_mem_read = 1; ex_rd = 0; id_rs1 = 0; id_use_rs1 = 1;
    #1;
    chk("x0_ctl", 32'(ctl()), 32'b1100100);

    // load-use on rs2 only
    @(negedge clk);
    idle();
    ex_mem_read = 1; ex_rd = 7; id_rs2 = 7; id_use_rs2 = 1; id_rs1 = 3;
    #1;
    chk("lu2_ctl", 32'(ctl()), 32'b0001100);
    chk("x0_cnt", stall_count, 1);

    // branch plus load-use: flush wins, no stall
    @(negedge clk);
    ex_branch_taken = 1;
    #1;
    chk("br_lu_ctl", 32'(ctl()), 32'b1111100);
    chk("lu2_cnt", stall_count, 2);
    @(negedge clk);
    idle();
    #1;
    chk("br_cnt", stall_count, 2);

    // memory wait: 3 frozen cycles, branch suppressed in one of them
    @(negedge clk);
    mem_mem_read = 1; dmem_ready = 0;
    #1;
    chk("mw_c1", 32'(ctl()), 32'b0000011);
    @(negedge clk);
    ex_branch_taken = 1;
    #1;
    chk("mw_c2", 32'(ctl()), 32'b0000011);
    @(negedge clk);
    ex_branch_taken = 0;
    #1;
    chk("mw_c3", 32'(ctl()), 32'b0000011);
    // ready on the cycle the counter sits at its limit: advance wins
    @(negedge clk);
    dmem_ready = 1;
    #1;
    chk("mw_go", 32'(ctl()), 32'b1100101);
    chk("mw_cnt3", stall_count, 5);
    @(negedge clk);
    idle();
    #1;
    chk("mw_run", 32'(ctl()), 32'b1100100);
    chk("mw_nohalt", 32'(halted), 0);
    chk("mw_cnt", stall_count, 5);

    // timeout: write with ready held low
    mem_mem_write = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("to_wait", 32'(ctl()), 32'b0000011);
      chk("to_halt0", 32'(halted), 0);
      @(negedge clk);
    end
    #1;
    chk("to_halted", 32'(halted), 1);
    chk("to_err", 32'(timeout_err), 1);
    chk("to_ctl", 32'(ctl()), 32'b0001010);
    chk("to_cnt", stall_count, 9);
    @(negedge clk);
    idle();
    dmem_ready = 1;
    #1;
    chk("halt_hold", 32'(halted), 1);
    chk("halt_cnt", stall_count, 9);

    // reset out of HALT
    @(negedge clk);
    rst = 1;
    #1;
    chk("rst2_ctl", 32'(ctl()), 32'b0011010);
    @(negedge clk);
    rst = 0;
    idle();
    #1;
    chk("rst2_halt", 32'(halted), 0);
    chk("rst2_to", 32'(timeout_err), 0);
    chk("rst2_cnt", stall_count, 0);
    chk("rst2_ctl_run", 32'(ctl()), 32'b1100100);

    // illegal with no hazards: current cycle normal, then halt
    id_illegal = 1;
    #1;
    chk("ill_ctl", 32'(ctl()), 32'b1100100);
    @(negedge clk);
    idle();
    #1;
    chk("ill_halt", 32'(halted), 1);
    chk("ill_to", 32'(timeout_err), 0);
    @(negedge clk);
    #1;
    chk("ill_cnt", stall_count, 0);

    @(negedge clk);
    rst = 1;
    @(negedge clk);
    rst = 0;
    // illegal squashed by a taken branch
    id_illegal = 1; ex_branch_taken = 1;
    @(negedge clk);
    idle();
    #1;
    chk("ill_br", 32'(halted), 0);

    // reset during the second stalled cycle
    @(negedge clk);
    mem_mem_read = 1;
    @(negedge clk);
    #1;
    chk("rmw_cnt1", stall_count, 1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    idle();
    #1;
    chk("rmw_ctl", 32'(ctl()), 32'b1100100);
    chk("rmw_cnt", stall_count, 0);
    // a fresh wait must again take the full four stalls to time out
    mem_mem_read = 1;
    repeat (3) @(negedge clk);
    #1;
    chk("rmw_nohalt", 32'(halted), 0);
    @(negedge clk);
    #1;
    chk("rmw_halt", 32'(halted), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
